// File: rtl/dir_btn_encoder.sv
// Four push buttons -> 2-bit direction code with a held flag and a new-direction strobe.
// Each button is synchronised and debounced; the lowest-index held button wins; game-over locks the output.
module dir_btn_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       gameOver,
  output logic [1:0] num,
  output logic       pressed,
  output logic       new_dir,
  output logic [1:0] state_dbg_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    deb_q, deb_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  state_t        state_q, state_d;
  logic [1:0]    num_q, num_d;
  logic          pressed_q, pressed_d;
  logic          new_dir_q, new_dir_d;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    pressed_d = pressed_q;
    new_dir_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        pressed_d = 1'b0;
        if (gameOver) begin
          state_d = S_LOCKED;
        end else if (|deb_q) begin
          num_d     = lowest_set(deb_q);
          pressed_d = 1'b1;
          new_dir_d = 1'b1;
          state_d   = S_HELD;
        end
      end
      S_HELD: begin
        if (gameOver) begin
          state_d   = S_LOCKED;
          pressed_d = 1'b0;
        end else if (deb_q[num_q]) begin
          pressed_d = 1'b1;
        end else if (|deb_q) begin
          // Roll over to the next held button without dropping pressed.
          num_d     = lowest_set(deb_q);
          pressed_d = 1'b1;
          new_dir_d = 1'b1;
        end else begin
          state_d   = S_IDLE;
          pressed_d = 1'b0;
        end
      end
      S_LOCKED: begin
        pressed_d = 1'b0;
        // Require all buttons released so a press held across game-over cannot re-fire.
        if (!gameOver && (deb_q == 4'd0)) state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        pressed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      state_q   <= S_IDLE;
      num_q     <= 2'd0;
      pressed_q <= 1'b0;
      new_dir_q <= 1'b0;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      state_q   <= state_d;
      num_q     <= num_d;
      pressed_q <= pressed_d;
      new_dir_q <= new_dir_d;
    end
  end

  assign num         = num_q;
  assign pressed     = pressed_q;
  assign new_dir     = new_dir_q;
  assign state_dbg_o = state_q;

endmodule
